seq_det_param: RTL and testbench

- Parametrised Moore-style serial pattern detector. Successor to the fixed 4-bit "1011" non-overlapping detector.
- Pattern width and value are set by parameters. Overlap/non-overlap mode is selectable at run time. Input is qualified by a valid strobe.
- A saturating match counter supports link and bitstream monitoring in the serial-protocol blocks.

---
 rtl/seq_det_param.sv | 64 ++++++
 tb/tb_seq_det_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
// seq_det_param: parameterised Moore serial pattern detector.
// Keeps a sliding window of the last PAT_W consumed bits plus a fill count and
// compares the whole window against PATTERN, so any pattern (including
// self-overlapping ones) is detected exactly. Runtime overlap select, valid
// qualified input, saturating match counter with a sticky saturation flag.
module seq_det_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic             din,
  input  logic             ovl_en,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int             FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist, nhist;
  logic [FW-1:0]    fill, nfill;
  logic             match;

  // Window after the incoming bit, saturated fill count, and the match decision
  always_comb begin
    nhist = {hist[PAT_W-2:0], din};
    nfill = (fill == FULL) ? FULL : fill + FW'(1);
    match = din_vld && (nfill == FULL) && (nhist == PATTERN);
  end

  // History window and fill; a non-overlap match empties the window
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (din_vld) begin
      hist <= nhist;
      if (match) fill <= ovl_en ? FULL : '0;
      else       fill <= nfill;
    end
  end

  // Registered match pulse; cleared on idle cycles so it lasts one cycle
  always_ff @(posedge clk) begin
    if (rst) y <= 1'b0;
    else     y <= match;
  end

  // Saturating match counter; sticky flag set by a match at the ceiling
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (match) begin
      if (match_cnt != {CNT_W{1'b1}}) match_cnt <= match_cnt + CNT_W'(1);
      else                            cnt_sat   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: three instances share the stimulus.
//   A: default 1011 / CNT_W=8   B: 1011 / CNT_W=2   C: pattern 11 / CNT_W=8
module tb_seq_det_param;

  logic clk = 1'b0;
  logic rst, din_vld, din, ovl_en;

  logic       ya, yb, yc;
  logic [7:0] cnta, cntc;
  logic [1:0] cntb;
  logic       sata, satb, satc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_det_param u_a (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .ovl_en(ovl_en),
    .y(ya), .match_cnt(cnta), .cnt_sat(sata)
  );

  seq_det_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .ovl_en(ovl_en),
    .y(yb), .match_cnt(cntb), .cnt_sat(satb)
  );

  seq_det_param #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .ovl_en(ovl_en),
    .y(yc), .match_cnt(cntc), .cnt_sat(satc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic yof(input int sel);
    case (sel)
      0:       return ya;
      1:       return yb;
      default: return yc;
    endcase
  endfunction

  // one clock with the given inputs; outputs sampled 1 time unit after the edge
  task automatic step(input string tag, input int sel, input logic vld,
                      input logic d, input logic ey);
    din_vld = vld;
    din     = d;
    @(posedge clk);
    #1;
    chk(tag, yof(sel), ey);
  endtask

  // reset held with din_vld=1 to show reset wins
  task automatic do_rst();
    rst = 1'b1; din_vld = 1'b1; din = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; din_vld = 1'b0;
  endtask

  // consume n bits (MSB of bits[n-1:0] first), checking y after each
  task automatic run_seq(input string tag, input int sel, input int n,
                         input logic [15:0] bits, input logic [15:0] ey);
    for (int i = n - 1; i >= 0; i--)
      step($sformatf("%s.b%0d", tag, n - i), sel, 1'b1, bits[i], ey[i]);
    din_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b0; din_vld = 1'b0; din = 1'b0; ovl_en = 1'b0;
    #2;

    // reset state
    do_rst();
    chk("rst.y",   ya,   0);
    chk("rst.cnt", cnta, 0);
    chk("rst.sat", sata, 0);

    // basic 1011 match, then idle drops y
    ovl_en = 1'b0;
    run_seq("basic", 0, 4, 16'b1011, 16'b0001);
    chk("basic.cnt", cnta, 1);
    chk("basic.sat", sata, 0);
    step("basic.idle", 0, 1'b0, 1'b0, 1'b0);

    // non-overlap vs overlap on 1011011
    do_rst();
    ovl_en = 1'b0;
    run_seq("novl", 0, 7, 16'b1011011, 16'b0001000);
    chk("novl.cnt", cnta, 1);
    do_rst();
    ovl_en = 1'b1;
    run_seq("ovl", 0, 7, 16'b1011011, 16'b0001001);
    chk("ovl.cnt", cnta, 2);

    // spec example: 101011 non-overlap matches at bit 6
    do_rst();
    ovl_en = 1'b0;
    run_seq("ex6", 0, 6, 16'b101011, 16'b000001);

    // partial-match recovery
    do_rst();
    run_seq("part", 0, 7, 16'b1101011, 16'b0000001);
    chk("part.cnt", cnta, 1);

    // valid gaps
    do_rst();
    step("gap.1",  0, 1'b1, 1'b1, 1'b0);
    step("gap.i1", 0, 1'b0, 1'b0, 1'b0);
    step("gap.i2", 0, 1'b0, 1'b1, 1'b0);
    step("gap.i3", 0, 1'b0, 1'b0, 1'b0);
    step("gap.0",  0, 1'b1, 1'b0, 1'b0);
    step("gap.i4", 0, 1'b0, 1'b1, 1'b0);
    step("gap.1b", 0, 1'b1, 1'b1, 1'b0);
    step("gap.i5", 0, 1'b0, 1'b0, 1'b0);
    step("gap.i6", 0, 1'b0, 1'b0, 1'b0);
    step("gap.1c", 0, 1'b1, 1'b1, 1'b1);
    step("gap.i7", 0, 1'b0, 1'b1, 1'b0);
    step("gap.i8", 0, 1'b0, 1'b0, 1'b0);
    chk("gap.cnt", cnta, 1);

    // saturation on the 2-bit counter
    do_rst();
    ovl_en = 1'b0;
    for (int m = 1; m <= 5; m++) begin
      run_seq($sformatf("sat%0d", m), 1, 4, 16'b1011, 16'b0001);
      chk($sformatf("sat%0d.cnt", m), cntb, (m > 3) ? 3 : m);
      chk($sformatf("sat%0d.flag", m), satb, (m >= 4) ? 1 : 0);
    end
    step("sat.idle", 1, 1'b0, 1'b0, 1'b0);
    chk("sat.sticky", satb, 1);
    do_rst();
    chk("sat.rstflag", satb, 0);
    chk("sat.rstcnt",  cntb, 0);

    // reset mid-pattern discards history
    do_rst();
    run_seq("mid.a", 0, 3, 16'b101, 16'b000);
    do_rst();
    chk("mid.rsty",   ya,   0);
    chk("mid.rstcnt", cnta, 0);
    run_seq("mid.b", 0, 1, 16'b1, 16'b0);
    run_seq("mid.c", 0, 3, 16'b011, 16'b001);
    chk("mid.cnt", cnta, 1);

    // pattern 11: back-to-back pulses with overlap, none without
    do_rst();
    ovl_en = 1'b1;
    run_seq("p11o", 2, 3, 16'b111, 16'b011);
    chk("p11o.cnt", cntc, 2);
    do_rst();
    ovl_en = 1'b0;
    run_seq("p11n", 2, 3, 16'b111, 16'b010);
    chk("p11n.cnt", cntc, 1);

    // ovl_en switched between bits applies on the next consumed bit
    do_rst();
    ovl_en = 1'b1;
    run_seq("sw.a", 2, 2, 16'b11, 16'b01);
    ovl_en = 1'b0;
    run_seq("sw.b", 2, 2, 16'b11, 16'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
